// File: rtl/wbledpwm_pkg.sv
// Shared definitions for the wbledpwm_fade LED PWM slave.
// Holds the register map (byte offsets within the decoded window),
// CTRL bit positions, the channel IMM strobe bit, the decoded register
// selector and a byte-lane merge helper for 16-bit registers.
package wbledpwm_pkg;

  localparam logic [6:0] REG_CTRL      = 7'h00;
  localparam logic [6:0] REG_PRESCALE  = 7'h04;
  localparam logic [6:0] REG_FADE_RATE = 7'h08;
  localparam logic [6:0] REG_STATUS    = 7'h0C;
  localparam logic [6:0] REG_CH_BASE   = 7'h10;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_INV   = 1;
  localparam int unsigned CH_IMM_BIT = 31;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PRESCALE,
    SEL_FADE_RATE,
    SEL_STATUS,
    SEL_CH
  } reg_sel_e;

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  sel);
    logic [15:0] r;
    r = old_v;
    if (sel[0]) r[7:0]  = new_v[7:0];
    if (sel[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

endpackage

// File: rtl/wbledpwm_chan.sv
// One LED PWM channel: target and live duty (cur) registers, the fade
// step toward target, IMM override, and the registered PWM comparator.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cnt                 shared PWM counter
//   boundary, step      period wrap, and fade step (only at a wrap)
//   en, inv             CTRL enable / output inversion
//   wr_en, wr_data,     channel register write strobe, data (PW bits),
//   wr_sel, wr_imm      byte lanes [1:0], IMM strobe (lane-qualified)
//   target_o, cur_o     register values for readback / busy status
//   led                 PWM output, one cycle behind the compare inputs
module wbledpwm_chan
  import wbledpwm_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] cnt,
  input  logic          boundary,
  input  logic          step,
  input  logic          en,
  input  logic          inv,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_data,
  input  logic [1:0]    wr_sel,
  input  logic          wr_imm,
  output logic [PW-1:0] target_o,
  output logic [PW-1:0] cur_o,
  output logic          led
);

  logic [PW-1:0] target_q, target_d;
  logic [PW-1:0] cur_q, cur_d;
  logic          led_q, led_d;
  logic [PW-1:0] tgt_wr;

  always_comb begin
    tgt_wr = target_q;
    for (int unsigned b = 0; b < PW; b++) begin
      if (wr_sel[b/8]) tgt_wr[b] = wr_data[b];
    end

    target_d = target_q;
    cur_d    = cur_q;
    // The step compares against the registered target, so a same-cycle
    // non-IMM write only takes effect from the next step onward.
    if (step && boundary) begin
      if (cur_q < target_q)      cur_d = cur_q + PW'(1);
      else if (cur_q > target_q) cur_d = cur_q - PW'(1);
    end
    if (wr_en) begin
      target_d = tgt_wr;
      if (wr_imm) cur_d = tgt_wr;
    end

    led_d = (en & (cnt < cur_q)) ^ inv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      cur_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      led_q    <= led_d;
    end
  end

  assign target_o = target_q;
  assign cur_o    = cur_q;
  assign led      = led_q;

endmodule

// File: rtl/wbledpwm_fade.sv
// Multi-channel Wishbone LED PWM driver with prescaler and hardware fade.
// Top level: Wishbone register decode, prescaler, PWM counter and fade
// interval counter; NCH wbledpwm_chan instances hold per-channel state.
// Ports:
//   wb_clk_i, wb_reset_ni   clock, asynchronous active-low reset
//   wb_adr_i                byte address, bits [6:2] decoded
//   wb_dat_i, wb_dat_o      write data / registered read data
//   wb_we_i, wb_sel_i       write enable, byte lanes
//   wb_cyc_i, wb_stb_i      cycle / strobe
//   wb_ack_o                one-cycle acknowledge
//   leds                    PWM outputs, active high
module wbledpwm_fade
  import wbledpwm_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_ni,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic [NCH-1:0]  leds
);

  localparam logic [4:0] CH_WORD = REG_CH_BASE[6:2];

  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   prescale_q, prescale_d;
  logic [15:0]   fade_rate_q, fade_rate_d;
  logic [15:0]   pre_cnt_q, pre_cnt_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [15:0]   fade_cnt_q, fade_cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;

  logic [4:0]    word;
  logic [6:0]    reg_off;
  logic [4:0]    ch_idx;
  reg_sel_e      reg_sel;
  logic          req, wr;
  logic          en, inv, tick, boundary, step;
  logic [31:0]   rd_data;
  logic [NCH-1:0] ch_wr, busy;
  logic [PW-1:0] ch_tgt [NCH];
  logic [PW-1:0] ch_cur [NCH];

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[AW-1:7], wb_adr_i[1:0], wb_dat_i[30:16], wb_sel_i[2]};

  assign word    = wb_adr_i[6:2];
  assign reg_off = {word, 2'b00};
  assign ch_idx  = word - CH_WORD;
  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr      = req & wb_we_i;
  assign en      = ctrl_q[CTRL_EN];
  assign inv     = ctrl_q[CTRL_INV];

  always_comb begin
    case (reg_off)
      REG_CTRL:      reg_sel = SEL_CTRL;
      REG_PRESCALE:  reg_sel = SEL_PRESCALE;
      REG_FADE_RATE: reg_sel = SEL_FADE_RATE;
      REG_STATUS:    reg_sel = SEL_STATUS;
      default: begin
        if (word >= CH_WORD && {1'b0, ch_idx} < 6'(NCH)) reg_sel = SEL_CH;
        else                                             reg_sel = SEL_NONE;
      end
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      SEL_CTRL:      rd_data[1:0]  = ctrl_q;
      SEL_PRESCALE:  rd_data[15:0] = prescale_q;
      SEL_FADE_RATE: rd_data[15:0] = fade_rate_q;
      SEL_STATUS:    rd_data       = 32'(busy);
      SEL_CH: begin
        for (int unsigned n = 0; n < NCH; n++) begin
          if (ch_idx == 5'(n)) begin
            rd_data[PW-1:0]     = ch_tgt[n];
            rd_data[PW+15:16]   = ch_cur[n];
          end
        end
      end
      default: rd_data = '0;
    endcase
  end

  // Counters are all held at zero while disabled, so enabling always
  // starts a fresh period and fade interval.
  assign tick     = (pre_cnt_q == prescale_q);
  assign boundary = en & tick & (cnt_q == '1);
  assign step     = boundary & (fade_cnt_q == fade_rate_q);

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    fade_rate_d = fade_rate_q;
    if (wr) begin
      case (reg_sel)
        SEL_CTRL:      if (wb_sel_i[0]) ctrl_d = wb_dat_i[1:0];
        SEL_PRESCALE:  prescale_d  = merge16(prescale_q, wb_dat_i[15:0], wb_sel_i[1:0]);
        SEL_FADE_RATE: fade_rate_d = merge16(fade_rate_q, wb_dat_i[15:0], wb_sel_i[1:0]);
        default: ;
      endcase
    end

    pre_cnt_d  = '0;
    cnt_d      = '0;
    fade_cnt_d = '0;
    if (en) begin
      pre_cnt_d  = tick ? '0 : pre_cnt_q + 16'd1;
      cnt_d      = tick ? cnt_q + PW'(1) : cnt_q;
      fade_cnt_d = fade_cnt_q;
      if (boundary) fade_cnt_d = step ? '0 : fade_cnt_q + 16'd1;
    end

    ack_d = req;
    dat_d = '0;
    if (req && !wb_we_i) dat_d = rd_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      fade_rate_q <= '0;
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      fade_cnt_q  <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      fade_rate_q <= fade_rate_d;
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      fade_cnt_q  <= fade_cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign ch_wr[n] = wr & (reg_sel == SEL_CH) & (ch_idx == 5'(n));
    assign busy[n]  = (ch_cur[n] != ch_tgt[n]);

    wbledpwm_chan #(.PW(PW)) u_chan (
      .clk      (wb_clk_i),
      .rst_n    (wb_reset_ni),
      .cnt      (cnt_q),
      .boundary (boundary),
      .step     (step),
      .en       (en),
      .inv      (inv),
      .wr_en    (ch_wr[n]),
      .wr_data  (wb_dat_i[PW-1:0]),
      .wr_sel   (wb_sel_i[1:0]),
      .wr_imm   (wb_sel_i[3] & wb_dat_i[CH_IMM_BIT]),
      .target_o (ch_tgt[n]),
      .cur_o    (ch_cur[n]),
      .led      (leds[n])
    );
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wbledpwm_fade.sv
// Self-checking bench for wbledpwm_fade (NCH=4, PW=8).
module tb_wbledpwm_fade;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_i, dat_o;
  logic        we, cyc, stb, ack;
  logic [3:0]  sel;
  logic [3:0]  leds;

  int errors = 0;
  int checks = 0;
  int unsigned cyc_cnt = 0;

  wbledpwm_fade #(.AW(32), .DW(32), .NCH(4), .PW(8)) dut (
    .wb_clk_i    (clk),
    .wb_reset_ni (rst_n),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_i),
    .wb_dat_o    (dat_o),
    .wb_we_i     (we),
    .wb_sel_i    (sel),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_ack_o    (ack),
    .leds        (leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One Wishbone transfer; returns read data and the number of the
  // clock edge at which the request was sampled.
  task automatic bus(input logic w, input logic [6:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdata, output int unsigned rq);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(a); dat_i = d; sel = s;
    @(posedge clk); #1;
    rq = cyc_cnt;
    chk("ack_rise", 32'(ack), 32'd1);
    rdata = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; int unsigned q;
    bus(1'b1, a, d, s, r, q);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] r; int unsigned q;
    bus(1'b0, a, 32'h0, 4'hF, r, q);
    chk(name, r, exp);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc_cnt < c) begin @(posedge clk); #1; end
  endtask

  task automatic clear_chans();
    for (int n = 0; n < 4; n++) wr(7'(16 + 4*n), 32'h8000_0000, 4'hF);
  endtask

  // Reference: live duty after k fade steps from c toward tg.
  function automatic int move_toward(input int c, input int tg, input int k);
    if (c < tg) return (c + k > tg) ? tg : c + k;
    return (c - k < tg) ? tg : c - k;
  endfunction

  logic [31:0] r;
  int unsigned rq, e0;

  initial begin
    int hi [4];
    int c0 [4];
    int tg [4];
    int p, f, s_len, t, k, cm, lows;
    logic iv;
    logic [3:0] exp_l;
    int fade_t [5] = '{100, 600, 1100, 1600, 2100};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 32; a += 4) rd_chk("rst_reg", 7'(a), 32'h0);
    rd_chk("rst_unmapped", 7'h7C, 32'h0);

    // Register behaviour with EN=0 (nothing moves)
    tbl.push_back('{1'b1, 7'h04, 32'h0000_1200, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h04, 32'h0,         4'hF, 32'h0000_1200});
    tbl.push_back('{1'b1, 7'h04, 32'h0000_00FF, 4'h1, 32'h0});
    tbl.push_back('{1'b0, 7'h04, 32'h0,         4'hF, 32'h0000_12FF});
    tbl.push_back('{1'b1, 7'h08, 32'h0000_ABCD, 4'h2, 32'h0});
    tbl.push_back('{1'b0, 7'h08, 32'h0,         4'hF, 32'h0000_AB00});
    tbl.push_back('{1'b1, 7'h7C, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h7C, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 7'h10, 32'h8000_0040, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h10, 32'h0,         4'hF, 32'h0040_0040});
    tbl.push_back('{1'b1, 7'h14, 32'h0000_0004, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h14, 32'h0,         4'hF, 32'h0000_0004});
    tbl.push_back('{1'b0, 7'h0C, 32'h0,         4'hF, 32'h0000_0002});
    tbl.push_back('{1'b1, 7'h10, 32'h8000_0000, 4'h7, 32'h0});
    tbl.push_back('{1'b0, 7'h10, 32'h0,         4'hF, 32'h0040_0000});
    tbl.push_back('{1'b0, 7'h0C, 32'h0,         4'hF, 32'h0000_0003});
    tbl.push_back('{1'b1, 7'h20, 32'h8000_00FF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h20, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 7'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 7'h0C, 32'h0,         4'hF, 32'h0000_0003});
    tbl.push_back('{1'b1, 7'h00, 32'h0000_0003, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 7'h00, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 7'h18, 32'h0000_1234, 4'h3, 32'h0});
    tbl.push_back('{1'b0, 7'h18, 32'h0,         4'hF, 32'h0000_0034});
    tbl.push_back('{1'b1, 7'h1C, 32'h8000_00A5, 4'h9, 32'h0});
    tbl.push_back('{1'b0, 7'h1C, 32'h0,         4'hF, 32'h00A5_00A5});
    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].data, tbl[i].sel);
      else           rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    clear_chans();
    wr(7'h04, 32'h0, 4'hF);
    wr(7'h08, 32'h0, 4'hF);

    // Duty: 0x40 and full-scale 0xFF at PRESCALE=0
    wr(7'h10, 32'h8000_0040, 4'hF);
    wr(7'h14, 32'h8000_00FF, 4'hF);
    wr(7'h00, 32'h1, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) hi[n] = 0;
    for (int i = 0; i < 256; i++) begin
      for (int n = 0; n < 4; n++) hi[n] += int'(leds[n]);
      @(posedge clk); #1;
    end
    chk("duty_ch0", 32'(hi[0]), 32'd64);
    chk("duty_ch1", 32'(hi[1]), 32'd255);
    chk("duty_ch2", 32'(hi[2]), 32'd0);
    chk("duty_ch3", 32'(hi[3]), 32'd0);

    // Fade: FADE_RATE=1, CH1 0 -> 4, one step per 512 cycles
    wr(7'h00, 32'h0, 4'hF);
    clear_chans();
    wr(7'h08, 32'h1, 4'hF);
    wr(7'h14, 32'h0000_0004, 4'hF);
    bus(1'b1, 7'h00, 32'h1, 4'hF, r, e0);
    for (int i = 0; i < 5; i++) begin
      wait_until(e0 + fade_t[i]);
      bus(1'b0, 7'h14, 32'h0, 4'hF, r, rq);
      cm = move_toward(0, 4, int'(rq - 1 - e0) / 512);
      chk("fade_ch1", r, (32'(cm) << 16) | 32'd4);
      bus(1'b0, 7'h0C, 32'h0, 4'hF, r, rq);
      cm = move_toward(0, 4, int'(rq - 1 - e0) / 512);
      chk("fade_status", r, (cm != 4) ? 32'h2 : 32'h0);
    end

    // Collisions with a step (FADE_RATE=0: step every 256 cycles)
    wr(7'h00, 32'h0, 4'hF);
    wr(7'h08, 32'h0, 4'hF);
    wr(7'h18, 32'h8000_0005, 4'hF);
    wr(7'h18, 32'h0000_0009, 4'hF);
    wr(7'h1C, 32'h8000_0010, 4'hF);
    wr(7'h1C, 32'h0000_0030, 4'hF);
    bus(1'b1, 7'h00, 32'h1, 4'hF, r, e0);
    wait_until(e0 + 255);
    bus(1'b1, 7'h18, 32'h0000_0002, 4'hF, r, rq);
    chk("coll_edge_a", rq - e0, 32'd256);
    rd_chk("coll_nonimm", 7'h18, 32'h0006_0002);
    wait_until(e0 + 511);
    bus(1'b1, 7'h1C, 32'h8000_0020, 4'hF, r, rq);
    chk("coll_edge_b", rq - e0, 32'd512);
    rd_chk("coll_imm", 7'h1C, 32'h0020_0020);
    rd_chk("coll_down", 7'h18, 32'h0005_0002);

    // Randomised runs against the arithmetic model
    for (int it = 0; it < 5; it++) begin
      p  = $urandom_range(0, 1);
      f  = $urandom_range(0, 1);
      iv = 1'($urandom_range(0, 1));
      wr(7'h00, 32'h0, 4'hF);
      wr(7'h04, 32'(p), 4'hF);
      wr(7'h08, 32'(f), 4'hF);
      for (int n = 0; n < 4; n++) begin
        c0[n] = $urandom_range(0, 255);
        tg[n] = c0[n] + $urandom_range(0, 6) - 3;
        if (tg[n] < 0) tg[n] = 0;
        if (tg[n] > 255) tg[n] = 255;
        wr(7'(16 + 4*n), 32'h8000_0000 | 32'(c0[n]), 4'hF);
        wr(7'(16 + 4*n), 32'(tg[n]), 4'hF);
      end
      bus(1'b1, 7'h00, {30'h0, iv, 1'b1}, 4'hF, r, e0);
      s_len = (p + 1) * 256 * (f + 1);
      for (int i = 0; i < 3 * s_len + 50; i++) begin
        t = int'(cyc_cnt - e0) - 1;
        k = t / s_len;
        for (int n = 0; n < 4; n++)
          exp_l[n] = (((t / (p + 1)) % 256) < move_toward(c0[n], tg[n], k)) ^ iv;
        chk("rand_leds", 32'(leds), 32'(exp_l));
        @(posedge clk); #1;
      end
      for (int n = 0; n < 4; n++) begin
        bus(1'b0, 7'(16 + 4*n), 32'h0, 4'hF, r, rq);
        cm = move_toward(c0[n], tg[n], int'(rq - 1 - e0) / s_len);
        chk("rand_ch", r, (32'(cm) << 16) | 32'(tg[n]));
      end
    end

    // Mode: INV with EN=0, then EN=1 with cur=0
    wr(7'h00, 32'h0, 4'hF);
    clear_chans();
    wr(7'h00, 32'h2, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    chk("mode_inv", 32'(leds), 32'hF);
    rd_chk("mode_ctrl", 7'h00, 32'h2);
    wr(7'h00, 32'h3, 4'hF);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (leds != 4'hF) lows++;
      @(posedge clk); #1;
    end
    chk("mode_en_inv_lows", 32'(lows), 32'd0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_ack", 32'(ack), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    rd_chk("post_rst_ctrl", 7'h00, 32'h0);
    rd_chk("post_rst_ch0", 7'h10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
